// File: rtl/frame_wr_ctrl_if.sv
// frame_wr_ctrl_if: burst command handshake between the
// frame write scheduler (master) and the AXI write engine (slave).
interface frame_wr_ctrl_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [8:0]  len;
    logic        done;

    modport master (
        output valid, addr, len,
        input  ready, done
    );

    modport slave (
        input  valid, addr, len,
        output ready, done
    );
endinterface

// File: rtl/frame_wr_ctrl.sv
// frame_wr_ctrl: video write-side burst scheduler with frame-buffer rotation.
// Define FRAME_SKIP_EN to skip the buffer currently held by the read side.
module frame_wr_ctrl #(
    parameter int          NUM_FB         = 3,
    parameter logic [31:0] FB_BASE        = 32'h0,
    parameter logic [31:0] FB_STRIDE      = 32'h0080_0000,
    parameter int          BYTES_PER_BEAT = 8,
    parameter int          PIX_PER_BEAT   = 2,
    parameter int          BURST_LEN      = 16,
    parameter int          FIFO_AW        = 9,
    parameter int          AF_MARGIN      = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             falign,
    input  logic             ealign,
    input  logic             odata_vld,
    input  logic [FIFO_AW:0] fifo_count,
    input  logic [1:0]       rd_frame_index,
    frame_wr_ctrl_if.master  cmd,
    output logic             fifo_almost_full,
    output logic             fifo_flush,
    output logic [1:0]       wr_frame_index,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int          BEAT_SH = $clog2(BYTES_PER_BEAT);
    localparam int          PIX_SH  = $clog2(PIX_PER_BEAT);
    localparam logic [31:0] AF_TH   = 32'(2**FIFO_AW - AF_MARGIN);
    localparam logic [1:0]  LAST_FB = 2'(NUM_FB - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_FRAME, WAIT_DATA, ISSUE,
        WAIT_DONE, FRAME_END, ABORT
    } state_t;

    state_t      state;
    logic [1:0]  nxt_fb;
    logic [31:0] remaining;
    logic [31:0] addr;

    logic        start;
    logic [1:0]  sel_fb;
    logic [31:0] prod;
    logic [32:0] rnd;
    logic [31:0] beats;
    logic [31:0] fb_addr;
    logic [8:0]  nlen;
    logic        data_ok;
    logic        unused_in;

    function automatic logic [1:0] fb_inc(input logic [1:0] i);
        return (i >= LAST_FB) ? 2'd0 : i + 2'd1;
    endfunction

    assign start = falign & odata_vld;

    always_comb begin
        sel_fb = nxt_fb;
`ifdef FRAME_SKIP_EN
        if (NUM_FB >= 3 && sel_fb == rd_frame_index)
            sel_fb = fb_inc(sel_fb);
`endif
    end

`ifdef FRAME_SKIP_EN
    assign unused_in = ealign;
`else
    assign unused_in = ^{rd_frame_index, ealign};
`endif

    assign prod    = 32'(hactive) * 32'(vactive);
    assign rnd     = {1'b0, prod} + 33'(PIX_PER_BEAT - 1);
    assign beats   = 32'(rnd >> PIX_SH);
    assign fb_addr = FB_BASE + 32'(sel_fb) * FB_STRIDE;
    assign nlen    = (remaining < 32'(BURST_LEN)) ?
                     remaining[8:0] : 9'(BURST_LEN);
    assign data_ok = 32'(fifo_count) >= 32'(nlen);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            nxt_fb           <= '0;
            remaining        <= '0;
            addr             <= '0;
            cmd.valid        <= 1'b0;
            cmd.addr         <= '0;
            cmd.len          <= '0;
            fifo_almost_full <= 1'b0;
            fifo_flush       <= 1'b0;
            wr_frame_index   <= '0;
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
            fifo_flush       <= 1'b0;
            fifo_almost_full <= 32'(fifo_count) >= AF_TH;
            unique case (state)
                IDLE: begin
                    if (enable) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (start) begin
                        wr_frame_index <= sel_fb;
                        nxt_fb         <= fb_inc(sel_fb);
                        addr           <= fb_addr;
                        remaining      <= beats;
                        if (beats == 0) begin
                            frame_done <= 1'b1;
                            state      <= FRAME_END;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (start) begin
                        frame_err  <= 1'b1;
                        fifo_flush <= 1'b1;
                        state      <= WAIT_FRAME;
                    end else if (data_ok) begin
                        cmd.valid <= 1'b1;
                        cmd.addr  <= addr;
                        cmd.len   <= nlen;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd.ready) begin
                        cmd.valid <= 1'b0;
                        remaining <= remaining - 32'(cmd.len);
                        addr      <= addr + (32'(cmd.len) << BEAT_SH);
                        frame_err <= start;
                        state     <= start ? ABORT : WAIT_DONE;
                    end else if (start) begin
                        // nothing in flight yet: withdraw and flush at once
                        cmd.valid  <= 1'b0;
                        frame_err  <= 1'b1;
                        fifo_flush <= 1'b1;
                        state      <= WAIT_FRAME;
                    end
                end
                WAIT_DONE: begin
                    if (start) begin
                        frame_err <= 1'b1;
                        if (cmd.done) begin
                            fifo_flush <= 1'b1;
                            state      <= WAIT_FRAME;
                        end else begin
                            state <= ABORT;
                        end
                    end else if (cmd.done) begin
                        if (remaining == 0) begin
                            frame_done <= 1'b1;
                            state      <= FRAME_END;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                FRAME_END: begin
                    state <= enable ? WAIT_FRAME : IDLE;
                end
                ABORT: begin
                    frame_err <= start;
                    if (cmd.done) begin
                        fifo_flush <= 1'b1;
                        state      <= WAIT_FRAME;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// tb_frame_wr_ctrl: scoreboard bench for frame_wr_ctrl, default parameters.
// Expected commands and completed buffer indices are queued at stimulus time.
module tb_frame_wr_ctrl;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] vactive = '0;
    logic [15:0] hactive = '0;
    logic        falign = 1'b0;
    logic        ealign = 1'b0;
    logic        odata_vld = 1'b0;
    logic [9:0]  fifo_count = 10'd511;
    logic [1:0]  rd_frame_index = 2'd3;
    logic        fifo_almost_full;
    logic        fifo_flush;
    logic [1:0]  wr_frame_index;
    logic        frame_done;
    logic        frame_err;

    frame_wr_ctrl_if cmd();

    frame_wr_ctrl dut (
        .clock            (clock),
        .rst_n            (rst_n),
        .enable           (enable),
        .vactive          (vactive),
        .hactive          (hactive),
        .falign           (falign),
        .ealign           (ealign),
        .odata_vld        (odata_vld),
        .fifo_count       (fifo_count),
        .rd_frame_index   (rd_frame_index),
        .cmd              (cmd.master),
        .fifo_almost_full (fifo_almost_full),
        .fifo_flush       (fifo_flush),
        .wr_frame_index   (wr_frame_index),
        .frame_done       (frame_done),
        .frame_err        (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  len;
    } cmd_t;

    cmd_t       sb[$];
    logic [1:0] exp_done[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0, vcyc = 0, hs_cnt = 0, fd_cnt = 0;
    int err_cnt = 0, fl_cnt = 0, done_cyc = 0, flush_cyc = 0;
    int stall = 0, done_lat = 3, pend = 0;
    bit outstanding = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [31:0] a, input logic [8:0] l);
        cmd_t c;
        c.addr = a;
        c.len  = l;
        return c;
    endfunction

    // write-engine model: optional ready stall, done after done_lat cycles
    initial begin
        cmd.ready = 1'b0;
        cmd.done  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cmd.done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) cmd.done = 1'b1;
            end
            if (cmd.ready) begin
                cmd.ready = 1'b0;
                pend = done_lat;
            end else if (cmd.valid) begin
                if (stall > 0) stall--;
                else cmd.ready = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (cmd.done && outstanding) begin
            outstanding = 0;
            done_cyc = cyc;
        end
        if (cmd.valid) begin
            vcyc++;
            chk("cmd_expected", 64'(sb.size() != 0), 1);
            chk("one_outstanding", 64'(outstanding), 0);
            if (sb.size() != 0) begin
                chk("cmd_addr", cmd.addr, sb[0].addr);
                chk("cmd_len", cmd.len, sb[0].len);
                if (cmd.ready) begin
                    void'(sb.pop_front());
                    outstanding = 1;
                    hs_cnt++;
                end
            end
        end
        if (frame_done) begin
            fd_cnt++;
            chk("done_expected", 64'(exp_done.size() != 0), 1);
            if (exp_done.size() != 0)
                chk("wr_frame_index", wr_frame_index, exp_done.pop_front());
        end
        if (frame_err) err_cnt++;
        if (fifo_flush) begin
            fl_cnt++;
            flush_cyc = cyc;
        end
    end

    task automatic wait_cnt(input string tag, input int sel,
                            input int target);
        int v;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            case (sel)
                0: v = fd_cnt;
                1: v = hs_cnt;
                default: v = fl_cnt;
            endcase
            if (v >= target) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic start_frame(input logic [15:0] h, input logic [15:0] v);
        repeat (2) @(posedge clock);
        #1;
        hactive   = h;
        vactive   = v;
        falign    = 1'b1;
        odata_vld = 1'b1;
        @(posedge clock);
        #1;
        falign    = 1'b0;
        odata_vld = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, cmd.valid, 0);
        chk({tag, "_addr"}, cmd.addr, 0);
        chk({tag, "_len"}, cmd.len, 0);
        chk({tag, "_af"}, fifo_almost_full, 0);
        chk({tag, "_flush"}, fifo_flush, 0);
        chk({tag, "_idx"}, wr_frame_index, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        int fd0, hs0;
        repeat (3) @(negedge clock);
        chk_outputs_zero("reset");
        @(posedge clock);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // full frame, four bursts into buffer 0
        for (int i = 0; i < 4; i++) sb.push_back(mk(32'h80 * i, 16));
        exp_done.push_back(2'd0);
        start_frame(64, 2);
        wait_cnt("t1_timeout", 0, 1);
        chk("t1_cmds", hs_cnt, 4);
        chk("t1_done_cnt", fd_cnt, 1);

        // 20 beats: 16 then 4, second waits for fifo level
        sb.push_back(mk(32'h0080_0000, 16));
        sb.push_back(mk(32'h0080_0080, 4));
        exp_done.push_back(2'd1);
        start_frame(40, 1);
        wait_cnt("t2_hs_timeout", 1, 5);
        @(posedge clock);
        #1;
        fifo_count = 10'd3;
        vcyc = 0;
        repeat (30) @(negedge clock);
        chk("t2_hold_low_fifo", vcyc, 0);
        @(posedge clock);
        #1;
        fifo_count = 10'd4;
        wait_cnt("t2_timeout", 0, 2);
        chk("t2_cmds", hs_cnt, 6);
        fifo_count = 10'd511;

        // ready stalled five cycles: command must stay put
        sb.push_back(mk(32'h0100_0000, 16));
        exp_done.push_back(2'd2);
        stall = 5;
        vcyc = 0;
        start_frame(32, 1);
        wait_cnt("t3_timeout", 0, 3);
        chk("t3_valid_cycles", vcyc, 6);

        // abort during second burst of buffer 0
        done_lat = 10;
        fd0 = fd_cnt;
        hs0 = hs_cnt;
        sb.push_back(mk(32'h0, 16));
        sb.push_back(mk(32'h80, 16));
        start_frame(64, 2);
        wait_cnt("t4_hs_timeout", 1, hs0 + 2);
        start_frame(64, 2);
        wait_cnt("t4_flush_timeout", 2, 1);
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_flush_cnt", fl_cnt, 1);
        chk("t4_flush_after_done", 64'(flush_cyc > done_cyc), 1);
        chk("t4_cmds", hs_cnt - hs0, 2);
        chk("t4_no_done", fd_cnt, fd0);
        done_lat = 3;
        sb.push_back(mk(32'h0080_0000, 16));
        exp_done.push_back(2'd1);
        start_frame(32, 1);
        wait_cnt("t4_restart_timeout", 0, fd0 + 1);

        // empty frame: no command, done still pulses
        hs0 = hs_cnt;
        exp_done.push_back(2'd2);
        start_frame(0, 5);
        wait_cnt("t_zero_timeout", 0, fd0 + 2);
        chk("zero_no_cmd", hs_cnt, hs0);

        // read side holds buffer 1 after buffer 0 completes
        rd_frame_index = 2'd1;
        sb.push_back(mk(32'h0, 16));
        exp_done.push_back(2'd0);
        start_frame(32, 1);
        wait_cnt("t5a_timeout", 0, fd0 + 3);
`ifdef FRAME_SKIP_EN
        sb.push_back(mk(32'h0100_0000, 16));
        exp_done.push_back(2'd2);
`else
        sb.push_back(mk(32'h0080_0000, 16));
        exp_done.push_back(2'd1);
`endif
        start_frame(32, 1);
        wait_cnt("t5b_timeout", 0, fd0 + 4);

        // almost-full threshold at 480 with one cycle latency
        @(posedge clock);
        #1;
        fifo_count = 10'd479;
        repeat (2) @(negedge clock);
        chk("af_479", fifo_almost_full, 0);
        @(posedge clock);
        #1;
        fifo_count = 10'd480;
        @(negedge clock);
        chk("af_latency", fifo_almost_full, 0);
        @(negedge clock);
        chk("af_480", fifo_almost_full, 1);

        // asynchronous reset while a command is pending
`ifdef FRAME_SKIP_EN
        sb.push_back(mk(32'h0, 16));
`else
        sb.push_back(mk(32'h0100_0000, 16));
`endif
        stall = 1000;
        start_frame(32, 1);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clock);
                seen = cmd.valid;
            end
            chk("rst_valid_seen", seen, 1);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        sb.delete();
        stall = 0;
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
